// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel key debouncer.
//   DB_*_DEF    default parameter values used by debounce_array / debounce_chan
//   db_cnt_w()  width of the per-channel stable counter for a given STABLE_CLKS
package debounce_pkg;

    localparam int unsigned DB_NUM_CH_DEF      = 4;
    localparam int unsigned DB_STABLE_CLKS_DEF = 1000;
    localparam int unsigned DB_SYNC_STAGES_DEF = 2;
    localparam int unsigned DB_DUR_W_DEF       = 16;

    // The counter only ever reaches STABLE_CLKS-1, so $clog2 bits suffice.
    function automatic int unsigned db_cnt_w(input int unsigned stable_clks);
        return (stable_clks < 2) ? 1 : $clog2(stable_clks);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser chain, stable counter, edge strobes and
// press-duration measurement.
//   clk, reset    system clock, synchronous active-high reset
//   raw_btn_i     asynchronous raw key input
//   db_btn_o      debounced level
//   rise_o        1-cycle strobe on the first cycle db_btn_o reads 1
//   fall_o        1-cycle strobe on the first cycle db_btn_o reads 0
//   dur_o         length of the last press (saturating)
//   dur_valid_o   1-cycle strobe with fall_o, dur_o updated in the same cycle
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CLKS = DB_STABLE_CLKS_DEF,
    parameter int unsigned SYNC_STAGES = DB_SYNC_STAGES_DEF,
    parameter int unsigned DUR_W       = DB_DUR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             raw_btn_i,
    output logic             db_btn_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [DUR_W-1:0] dur_o,
    output logic             dur_valid_o
);

    localparam int unsigned      CNT_W   = db_cnt_w(STABLE_CLKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CLKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q;
    logic [DUR_W-1:0]       hold_q;
    logic [DUR_W-1:0]       hold_inc;
    logic                   toggle;

    assign synced   = sync_q[SYNC_STAGES-1];
    assign toggle   = (synced != db_btn_o) && (cnt_q == CNT_MAX);
    assign hold_inc = (&hold_q) ? hold_q : hold_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            db_btn_o    <= 1'b0;
            rise_o      <= 1'b0;
            fall_o      <= 1'b0;
            dur_valid_o <= 1'b0;
            dur_o       <= '0;
            hold_q      <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_btn_i};

            rise_o      <= toggle && !db_btn_o;
            fall_o      <= toggle && db_btn_o;
            dur_valid_o <= toggle && db_btn_o;

            if (synced == db_btn_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q    <= '0;
                db_btn_o <= !db_btn_o;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // The release edge itself counts as a held cycle, so a press
            // visible from edge R to edge F reports F-R.
            if (db_btn_o) begin
                if (toggle) begin
                    dur_o  <= hold_inc;
                    hold_q <= '0;
                end else begin
                    hold_q <= hold_inc;
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

endmodule

// File: rtl/debounce_array.sv
// NUM_CH independent key debouncers with packed outputs.
//   clk, reset    system clock, synchronous active-high reset
//   raw_btn_i     raw inputs, bit n = channel n
//   db_btn_o      debounced levels
//   rise_o        per-channel press strobes
//   fall_o        per-channel release strobes
//   dur_o         last press length of channel n at [n*DUR_W +: DUR_W]
//   dur_valid_o   per-channel strobe, coincident with fall_o
module debounce_array
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH      = DB_NUM_CH_DEF,
    parameter int unsigned STABLE_CLKS = DB_STABLE_CLKS_DEF,
    parameter int unsigned SYNC_STAGES = DB_SYNC_STAGES_DEF,
    parameter int unsigned DUR_W       = DB_DUR_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       raw_btn_i,
    output logic [NUM_CH-1:0]       db_btn_o,
    output logic [NUM_CH-1:0]       rise_o,
    output logic [NUM_CH-1:0]       fall_o,
    output logic [NUM_CH*DUR_W-1:0] dur_o,
    output logic [NUM_CH-1:0]       dur_valid_o
);

    if (STABLE_CLKS < 2 || SYNC_STAGES < 2 || NUM_CH < 1) begin : g_bad_params
        $error("debounce_array: need STABLE_CLKS>=2, SYNC_STAGES>=2, NUM_CH>=1");
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        debounce_chan #(
            .STABLE_CLKS (STABLE_CLKS),
            .SYNC_STAGES (SYNC_STAGES),
            .DUR_W       (DUR_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .raw_btn_i   (raw_btn_i[n]),
            .db_btn_o    (db_btn_o[n]),
            .rise_o      (rise_o[n]),
            .fall_o      (fall_o[n]),
            .dur_o       (dur_o[n*DUR_W +: DUR_W]),
            .dur_valid_o (dur_valid_o[n])
        );
    end

endmodule

// File: tb/tb_debounce_array.sv
module tb_debounce_array;

    localparam int unsigned NUM_CH      = 2;
    localparam int unsigned STABLE_CLKS = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DUR_W       = 6;
    localparam int unsigned HIST        = SYNC_STAGES + STABLE_CLKS;
    localparam int unsigned DUR_MAX     = (1 << DUR_W) - 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       raw_btn_i;
    logic [NUM_CH-1:0]       db_btn_o;
    logic [NUM_CH-1:0]       rise_o;
    logic [NUM_CH-1:0]       fall_o;
    logic [NUM_CH*DUR_W-1:0] dur_o;
    logic [NUM_CH-1:0]       dur_valid_o;

    debounce_array #(
        .NUM_CH      (NUM_CH),
        .STABLE_CLKS (STABLE_CLKS),
        .SYNC_STAGES (SYNC_STAGES),
        .DUR_W       (DUR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_btn_i   (raw_btn_i),
        .db_btn_o    (db_btn_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .dur_o       (dur_o),
        .dur_valid_o (dur_valid_o)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    // Reference model: raw samples per edge; a level is accepted once the
    // last STABLE_CLKS synchronised samples all disagree with the current level.
    bit          hist [NUM_CH][HIST];
    bit          m_db [NUM_CH];
    bit          m_rise [NUM_CH];
    bit          m_fall [NUM_CH];
    int unsigned m_dur [NUM_CH];
    int unsigned rise_edge [NUM_CH];
    int unsigned edge_n = 0;

    int unsigned rise_cnt [NUM_CH];
    int unsigned fall_cnt [NUM_CH];
    int unsigned both_fall_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("FAIL %s @edge %0d: got=%0d expected=%0d", tag, edge_n, got, expected);
        end
    endtask

    task automatic model_edge();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit all_diff;
            m_rise[ch] = 1'b0;
            m_fall[ch] = 1'b0;
            if (reset) begin
                for (int k = 0; k < HIST; k++) hist[ch][k] = 1'b0;
                m_db[ch]  = 1'b0;
                m_dur[ch] = 0;
            end else begin
                for (int k = HIST - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = raw_btn_i[ch];
                all_diff = 1'b1;
                for (int k = SYNC_STAGES; k < HIST; k++)
                    if (hist[ch][k] == m_db[ch]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[ch] = !m_db[ch];
                    if (m_db[ch]) begin
                        m_rise[ch]    = 1'b1;
                        rise_edge[ch] = edge_n;
                    end else begin
                        m_fall[ch] = 1'b1;
                        m_dur[ch]  = (edge_n - rise_edge[ch] > DUR_MAX) ? DUR_MAX
                                                                       : edge_n - rise_edge[ch];
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("db%0d", ch),   32'(db_btn_o[ch]),    32'(m_db[ch]));
            check($sformatf("rise%0d", ch), 32'(rise_o[ch]),      32'(m_rise[ch]));
            check($sformatf("fall%0d", ch), 32'(fall_o[ch]),      32'(m_fall[ch]));
            check($sformatf("dv%0d", ch),   32'(dur_valid_o[ch]), 32'(m_fall[ch]));
            check($sformatf("dur%0d", ch),  32'(dur_o[ch*DUR_W +: DUR_W]), m_dur[ch]);
            rise_cnt[ch] += 32'(rise_o[ch]);
            fall_cnt[ch] += 32'(fall_o[ch]);
        end
        if (fall_o == 2'b11) both_fall_cnt++;
    endtask

    task automatic run(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rise_cnt[ch] = 0;
            fall_cnt[ch] = 0;
        end
        both_fall_cnt = 0;
    endtask

    initial begin
        int unsigned run_left [NUM_CH];

        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_db[ch] = 1'b0;
            m_dur[ch] = 0;
            rise_edge[ch] = 0;
            for (int k = 0; k < HIST; k++) hist[ch][k] = 1'b0;
        end
        clear_counts();

        // Reset state
        reset     = 1'b1;
        raw_btn_i = '0;
        run(3);
        reset = 1'b0;
        run(5);

        // Clean press of 20 cycles on ch0; db rises 10 edges after the step
        clear_counts();
        raw_btn_i[0] = 1'b1;
        run(9);
        check("s1_db_before", 32'(db_btn_o[0]), 0);
        run(1);
        check("s1_db_after", 32'(db_btn_o[0]), 1);
        run(10);
        raw_btn_i[0] = 1'b0;
        run(15);
        check("s1_dur", 32'(dur_o[5:0]), 20);
        check("s1_rises", rise_cnt[0], 1);
        check("s1_falls", fall_cnt[0], 1);

        // Bouncing press: toggles every 3 cycles then settles high
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            raw_btn_i[0] = (i % 2 == 0);
            run(3);
        end
        raw_btn_i[0] = 1'b1;
        run(9);
        check("s2_db_before", 32'(db_btn_o[0]), 0);
        run(1);
        check("s2_db_after", 32'(db_btn_o[0]), 1);
        run(5);
        check("s2_rises", rise_cnt[0], 1);
        check("s2_falls", fall_cnt[0], 0);
        raw_btn_i[0] = 1'b0;
        run(15);

        // ch1 glitches: 7 cycles rejected, 8 accepted
        clear_counts();
        raw_btn_i[1] = 1'b1;
        run(7);
        raw_btn_i[1] = 1'b0;
        run(20);
        check("s3_short_rises", rise_cnt[1], 0);
        raw_btn_i[1] = 1'b1;
        run(8);
        raw_btn_i[1] = 1'b0;
        run(20);
        check("s3_long_rises", rise_cnt[1], 1);
        check("s3_dur", 32'(dur_o[11:6]), 8);

        // Overlapping presses released together
        clear_counts();
        raw_btn_i[0] = 1'b1;
        run(3);
        raw_btn_i[1] = 1'b1;
        run(27);
        raw_btn_i = '0;
        run(15);
        check("s4_dur", 32'(dur_o), 32'({6'd27, 6'd30}));
        check("s4_both_fall", both_fall_cnt, 1);

        // Saturating duration then a short re-press
        raw_btn_i[0] = 1'b1;
        run(100);
        raw_btn_i[0] = 1'b0;
        run(15);
        check("s5_sat_dur", 32'(dur_o[5:0]), 63);
        raw_btn_i[0] = 1'b1;
        run(12);
        raw_btn_i[0] = 1'b0;
        run(15);
        check("s5_dur", 32'(dur_o[5:0]), 12);

        // Reset mid-press discards the press
        clear_counts();
        raw_btn_i[0] = 1'b1;
        run(15);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("s6_db_rst", 32'(db_btn_o), 0);
        check("s6_dur_rst", 32'(dur_o), 0);
        run(9);
        check("s6_db_early", 32'(db_btn_o[0]), 0);
        run(1);
        check("s6_db_back", 32'(db_btn_o[0]), 1);
        check("s6_falls", fall_cnt[0], 0);
        raw_btn_i[0] = 1'b0;
        run(15);

        // Random runs on both channels with occasional resets
        for (int ch = 0; ch < NUM_CH; ch++) run_left[ch] = $urandom_range(1, 20);
        for (int i = 0; i < 1500; i++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (run_left[ch] == 0) begin
                    raw_btn_i[ch] = !raw_btn_i[ch];
                    run_left[ch]  = $urandom_range(1, 20);
                end
                run_left[ch]--;
            end
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
